// File: rtl/gpu_pixel_arbiter.sv
// ---------------------------------------------------------------------------
// gpu_pixel_arbiter
//
// Purpose:
//   Shares the single memory-controller pixel-write path among three raster
//   engines (line=0, fill=1, arc=2). A round-robin arbiter grants one engine
//   per cycle into a 2-entry output FIFO that drives the memory controller.
//   Off-screen pixels are dropped and counted. A flush request stops new
//   grants, drains the FIFO and then pulses an acknowledge.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   req_valid_i    per-engine pixel valid, bit n = engine n
//   req_x_i        per-engine x, engine n at [n*WIDTH_BITS +: WIDTH_BITS]
//   req_y_i        per-engine y, engine n at [n*HEIGHT_BITS +: HEIGHT_BITS]
//   req_rgb_i      per-engine colour {r,g,b}, engine n at [n*3*CB +: 3*CB]
//   req_ready_o    one-hot grant; a pixel is taken when valid & ready
//   out_valid_o    FIFO head valid toward the memory controller
//   out_ready_i    memory controller accepts the head this cycle
//   out_x_o        head x
//   out_y_o        head y
//   out_rgb_o      head colour
//   flush_i        drain request (level), sampled in RUN
//   flush_done_o   one-cycle pulse when the drain completes
//   busy_o         FIFO non-empty or not in RUN
//   clip_count_o   saturating count of dropped off-screen pixels
//
// State table:
//   state    | meaning
//   ST_RUN   | normal operation, arbitration active
//   ST_DRAIN | no grants, waiting for the FIFO to empty
//   ST_DONE  | drain complete, flush_done_o high for this one cycle
// ---------------------------------------------------------------------------
module gpu_pixel_arbiter #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [2:0]                          req_valid_i,
    input  logic [3*WIDTH_BITS-1:0]             req_x_i,
    input  logic [3*HEIGHT_BITS-1:0]            req_y_i,
    input  logic [9*CHANNEL_BITS-1:0]           req_rgb_i,
    output logic [2:0]                          req_ready_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [WIDTH_BITS-1:0]               out_x_o,
    output logic [HEIGHT_BITS-1:0]              out_y_o,
    output logic [3*CHANNEL_BITS-1:0]           out_rgb_o,
    input  logic                                flush_i,
    output logic                                flush_done_o,
    output logic                                busy_o,
    output logic [15:0]                         clip_count_o
);

    localparam int RGB_BITS = 3 * CHANNEL_BITS;
    localparam int PIX_BITS = WIDTH_BITS + HEIGHT_BITS + RGB_BITS;

    // 32-bit unsigned copies so the on-screen compare needs no narrowing
    localparam logic [31:0] SCREEN_W_U = SCREEN_W;
    localparam logic [31:0] SCREEN_H_U = SCREEN_H;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [1:0]             count_q, count_d;
    logic [PIX_BITS-1:0]    slot0_q, slot0_d;
    logic [PIX_BITS-1:0]    slot1_q, slot1_d;
    logic [15:0]            clip_q, clip_d;

    logic                   arb_en;
    logic                   found;
    logic [1:0]             grant_idx;
    logic [1:0]             scan_idx;
    logic                   handshake;
    logic                   on_screen;
    logic                   push;
    logic                   pop;
    logic [WIDTH_BITS-1:0]  sel_x;
    logic [HEIGHT_BITS-1:0] sel_y;
    logic [RGB_BITS-1:0]    sel_rgb;
    logic [PIX_BITS-1:0]    push_pix;

    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Look at the post-pop occupancy so DONE follows the last pop directly
                if (count_d == 2'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // Reset gates every handshake-visible output so nothing is offered or
    // accepted during the reset cycle itself.
    // ------------------------------------------------------------------
    always_comb begin
        arb_en       = 1'b0;
        flush_done_o = 1'b0;
        out_valid_o  = 1'b0;
        req_ready_o  = 3'b000;
        out_x_o      = '0;
        out_y_o      = '0;
        out_rgb_o    = '0;
        busy_o       = (count_q != 2'd0) || (state_q != ST_RUN);
        if (!rst) begin
            // A full FIFO still has room if its head leaves this cycle
            arb_en       = (state_q == ST_RUN) && ((count_q != 2'd2) || out_ready_i);
            flush_done_o = (state_q == ST_DONE);
            out_valid_o  = (count_q != 2'd0);
            req_ready_o  = handshake ? (3'b001 << grant_idx) : 3'b000;
            out_x_o      = slot0_q[PIX_BITS-1 -: WIDTH_BITS];
            out_y_o      = slot0_q[RGB_BITS +: HEIGHT_BITS];
            out_rgb_o    = slot0_q[RGB_BITS-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin scan starting at ptr_q
    // ------------------------------------------------------------------
    always_comb begin
        found     = 1'b0;
        grant_idx = 2'd0;
        scan_idx  = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_valid_i[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    assign handshake = arb_en && found;

    always_comb begin
        sel_x   = req_x_i[grant_idx*WIDTH_BITS +: WIDTH_BITS];
        sel_y   = req_y_i[grant_idx*HEIGHT_BITS +: HEIGHT_BITS];
        sel_rgb = req_rgb_i[grant_idx*RGB_BITS +: RGB_BITS];
    end

    assign on_screen = ({{(32-WIDTH_BITS){1'b0}}, sel_x} < SCREEN_W_U) &&
                       ({{(32-HEIGHT_BITS){1'b0}}, sel_y} < SCREEN_H_U);
    assign push_pix  = {sel_x, sel_y, sel_rgb};
    assign push      = handshake && on_screen;
    assign pop       = out_valid_o && out_ready_i;

    // ------------------------------------------------------------------
    // Pointer and clip counter
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d  = ptr_q;
        clip_d = clip_q;
        if (handshake) begin
            ptr_d = wrap_inc(grant_idx);
            if (!on_screen && (clip_q != 16'hFFFF)) begin
                clip_d = clip_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-slot FIFO: slot0 is always the head, slot1 the tail when full
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (pop) begin
            slot0_d = slot1_q;
            if (push) begin
                if (count_q == 2'd1) begin
                    slot0_d = push_pix;
                end else begin
                    slot1_d = push_pix;
                end
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                slot0_d = push_pix;
            end else begin
                slot1_d = push_pix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= 2'd0;
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            clip_q  <= 16'd0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            clip_q  <= clip_d;
        end
    end

    assign clip_count_o = clip_q;

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpu_pixel_arbiter
//
// Purpose:
//   Self-checking bench for gpu_pixel_arbiter. A reference model tracks the
//   buffered pixels as a queue, the round-robin pointer, the flush phase and
//   the clip count; accepted on-screen pixels are pushed to a scoreboard
//   queue that a separate monitor pops whenever the DUT's head is taken.
// ---------------------------------------------------------------------------
module tb_gpu_pixel_arbiter;

    localparam int WB  = 10;
    localparam int HB  = 9;
    localparam int CB  = 8;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int PW  = WB + HB + 3*CB;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req_valid_i;
    logic [3*WB-1:0]   req_x_i;
    logic [3*HB-1:0]   req_y_i;
    logic [9*CB-1:0]   req_rgb_i;
    logic [2:0]        req_ready_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [WB-1:0]     out_x_o;
    logic [HB-1:0]     out_y_o;
    logic [3*CB-1:0]   out_rgb_o;
    logic              flush_i;
    logic              flush_done_o;
    logic              busy_o;
    logic [15:0]       clip_count_o;

    gpu_pixel_arbiter #(
        .WIDTH_BITS   (WB),
        .HEIGHT_BITS  (HB),
        .CHANNEL_BITS (CB),
        .SCREEN_W     (SW),
        .SCREEN_H     (SH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_x_i      (req_x_i),
        .req_y_i      (req_y_i),
        .req_rgb_i    (req_rgb_i),
        .req_ready_o  (req_ready_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_x_o      (out_x_o),
        .out_y_o      (out_y_o),
        .out_rgb_o    (out_rgb_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .busy_o       (busy_o),
        .clip_count_o (clip_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Scoreboard of pixels expected at the output, in order
    logic [PW-1:0] exp_q[$];

    // Reference model: phase 0=normal, 1=draining, 2=acknowledge cycle
    int m_cnt   = 0;
    int m_ptr   = 0;
    int m_phase = 0;
    int m_clip  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Model: checks control outputs each cycle, then advances one clock
    // ---------------------------------------------------------------
    always @(negedge clk) begin
        int g;
        int e;
        int nxt;
        bit free;
        logic [2:0] exp_rdy;
        logic [WB-1:0] px;
        logic [HB-1:0] py;
        logic [3*CB-1:0] pc;
        if (rst) begin
            chk("rst_ready", {61'd0, req_ready_o}, 64'd0);
            chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
            chk("rst_done", {63'd0, flush_done_o}, 64'd0);
            chk("rst_data", {21'd0, out_x_o, out_y_o, out_rgb_o}, 64'd0);
            m_cnt   = 0;
            m_ptr   = 0;
            m_phase = 0;
            m_clip  = 0;
            exp_q.delete();
        end else begin
            chk("out_valid", {63'd0, out_valid_o}, {63'd0, (m_cnt != 0)});
            chk("busy", {63'd0, busy_o}, {63'd0, (m_cnt != 0) || (m_phase != 0)});
            chk("flush_done", {63'd0, flush_done_o}, {63'd0, (m_phase == 2)});
            chk("clip_count", {48'd0, clip_count_o}, 64'(m_clip));

            free = (m_phase == 0) && ((m_cnt < 2) || (out_ready_i == 1'b1));
            g = -1;
            if (free) begin
                for (int k = 0; k < 3; k++) begin
                    e = (m_ptr + k) % 3;
                    if (g < 0 && req_valid_i[e]) g = e;
                end
            end
            exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
            chk("req_ready", {61'd0, req_ready_o}, {61'd0, exp_rdy});

            nxt = m_cnt;
            if (m_cnt > 0 && out_ready_i) nxt = nxt - 1;
            if (g >= 0) begin
                px = req_x_i[g*WB +: WB];
                py = req_y_i[g*HB +: HB];
                pc = req_rgb_i[g*3*CB +: 3*CB];
                if (int'(px) < SW && int'(py) < SH) begin
                    exp_q.push_back({px, py, pc});
                    nxt = nxt + 1;
                end else if (m_clip < 65535) begin
                    m_clip = m_clip + 1;
                end
                m_ptr = (g + 1) % 3;
            end
            case (m_phase)
                0: if (flush_i) m_phase = 1;
                1: if (nxt == 0) m_phase = 2;
                default: m_phase = 0;
            endcase
            m_cnt = nxt;
        end
    end

    // ---------------------------------------------------------------
    // Monitor: compares the presented head with the scoreboard
    // ---------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst && out_valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL head_unexpected: got %0h expected no pixel at %0t",
                         {out_x_o, out_y_o, out_rgb_o}, $time);
            end else begin
                chk("head_pixel", {21'd0, out_x_o, out_y_o, out_rgb_o}, {21'd0, exp_q[0]});
                if (out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_eng(input int e, input logic v, input int x, input int y, input logic [23:0] c);
        req_valid_i[e]             = v;
        req_x_i[e*WB +: WB]        = WB'(x);
        req_y_i[e*HB +: HB]        = HB'(y);
        req_rgb_i[e*3*CB +: 3*CB]  = c;
    endtask

    task automatic rand_eng(input int e, input logic v);
        set_eng(e, v, $urandom_range(0, SW - 1), $urandom_range(0, SH - 1), 24'($urandom));
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = '0;
        req_x_i     = '0;
        req_y_i     = '0;
        req_rgb_i   = '0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // single pixel from engine 0
        out_ready_i = 1'b1;
        set_eng(0, 1'b1, 5, 7, 24'h112233);
        step();
        req_valid_i = '0;
        repeat (3) step();

        // all three engines continuously
        for (int i = 0; i < 9; i++) begin
            for (int e = 0; e < 3; e++) rand_eng(e, 1'b1);
            step();
        end
        req_valid_i = '0;
        repeat (3) step();

        // back-pressure with engines 0 and 1
        out_ready_i = 1'b0;
        rand_eng(0, 1'b1);
        rand_eng(1, 1'b1);
        repeat (4) step();
        req_valid_i = '0;
        out_ready_i = 1'b1;
        repeat (4) step();

        // engine 2 sends two off-screen pixels
        set_eng(2, 1'b1, SW, 0, 24'hABCDEF);
        step();
        set_eng(2, 1'b1, 3, SH, 24'h010203);
        step();
        req_valid_i = '0;
        repeat (2) step();

        // flush with two buffered pixels, ready toggled 1/0/1
        out_ready_i = 1'b0;
        rand_eng(0, 1'b1);
        rand_eng(1, 1'b1);
        repeat (2) step();
        req_valid_i = '0;
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        step();
        out_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        repeat (3) step();

        // flush held high over an empty FIFO
        flush_i = 1'b1;
        repeat (6) step();
        flush_i = 1'b0;
        repeat (3) step();

        // reset during a drain with two buffered pixels
        out_ready_i = 1'b0;
        rand_eng(0, 1'b1);
        rand_eng(1, 1'b1);
        repeat (2) step();
        req_valid_i = '0;
        flush_i     = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            for (int e = 0; e < 3; e++) begin
                set_eng(e, ($urandom_range(0, 99) < 60), $urandom_range(0, 700),
                        $urandom_range(0, 520), 24'($urandom));
            end
            out_ready_i = ($urandom_range(0, 99) < 65);
            flush_i     = ($urandom_range(0, 99) < 4);
            rst         = ($urandom_range(0, 999) < 3);
            step();
        end
        rst         = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = '0;
        out_ready_i = 1'b1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
